ransac_iter_sequencer: RTL
==========================

// Module: ransac_iter_sequencer
// PURPOSE
//  Avalon-MM slave controller that sequences the RANSAC iteration datapath.
//  Nios II programs an iteration count and writes START. The block issues one dp_start per iteration,
//  waits for dp_done, and keeps the best score and its iteration index. Status is readable over the same
//  2-bit-address slave, with the same 1-cycle registered read as the system PIO ports.
// PARAMETERS
//  ITER_W   16  width of iteration count/index (max 2^ITER_W-1 iterations)
//  SCORE_W  32  width of datapath score (unsigned, higher is better)
// PORTS
//  clk          in   1        system clock; single clock domain
//  reset        in   1        asynchronous, active-high reset
//  address      in   2        word address: 0 CTRL, 1 NITER, 2 STATUS, 3 BEST
//  write        in   1        Avalon write strobe
//  writedata    in   32       write data
//  read         in   1        Avalon read strobe (data returned regardless, latency 1)
//  readdata     out  32       registered read data
//  dp_start     out  1        1-cycle pulse: datapath begins iteration dp_iter
//  dp_iter      out  ITER_W   index of current iteration, stable from dp_start until dp_done
//  dp_done      in   1        1-cycle pulse: datapath finished; dp_score valid same cycle
//  dp_score     in   SCORE_W  inlier score of finished iteration
//  irq          out  1        completion interrupt (present only with macro, see CONFIGURATION)
// BEHAVIOUR
//  Reset: readdata=0, dp_start=0, dp_iter=0, irq=0, niter=0, best_score=0, best_idx=0,
//   done=0, aborted=0, FSM=IDLE.
//  Registers: CTRL wr bit0=START, bit1=ABORT, bit2=IRQ_CLR (self-clearing, read as 0).
//   NITER r/w [ITER_W-1:0]. STATUS ro: bit0 busy, bit1 done, bit2 aborted, bit3 irq_pend,
//   [31:16] current dp_iter. BEST ro: score when SCORE_W=32; with SCORE_W<32,
//   {best_idx,best_score} packed low-aligned.
//  readdata <= mux(address) every clk, 1-cycle latency; unused bits 0.
//  FSM IDLE -> ISSUE on START when niter!=0: clear best_score/best_idx/done/aborted, dp_iter=0.
//   START with niter==0: no start, done=1 immediately (irq_pend set if enabled).
//  ISSUE: dp_start=1 for exactly one cycle -> WAIT.
//  WAIT: on dp_done -> UPDATE.
//  UPDATE: if dp_score > best_score (strict), best_score=dp_score, best_idx=dp_iter.
//   Ties keep earlier index. If dp_iter==niter-1 -> DONE, else dp_iter+=1 -> ISSUE.
//  DONE: done=1, busy=0, set irq_pend -> IDLE (same cycle transition, 1-cycle state).
//  busy=1 in ISSUE/WAIT/UPDATE. Min cycles per iteration: ISSUE+WAIT(>=1)+UPDATE = 3.
//  START while busy: ignored. Writes to NITER while busy: ignored (count latched at START).
//  ABORT while busy: FSM -> IDLE next cycle, aborted=1, done=0, no irq. Best registers retain
//   partial result. A dp_done arriving after abort is ignored. ABORT in IDLE: no effect.
//  START and ABORT in same write: ABORT wins (no start).
//  dp_done outside WAIT: ignored.
//  Reset asserted mid-run: all state to reset values asynchronously; no dp_start emitted.
// CONFIGURATION
//  RANSAC_SEQ_IRQ_EN defined: irq = irq_pend; irq_pend is set on DONE entry, cleared by IRQ_CLR
//   or by next accepted START. Simultaneous set and IRQ_CLR: set wins.
//  RANSAC_SEQ_IRQ_EN undefined: irq port tied 0, irq_pend logic removed, STATUS bit3 reads 0,
//   IRQ_CLR ignored.
// TESTING
//  1 Reset values: after reset, read all 4 addresses -> 0, irq=0, dp_start never pulses.
//  2 NITER=3 then START; datapath answers with dp_done after 2 cycles. Scores 5,9,9 ->
//    3 dp_start pulses (iter 0,1,2), BEST score=9 idx=1, STATUS done=1 busy=0, irq=1 (if enabled).
//  3 NITER=4, START, ABORT during iteration 1 WAIT; late dp_done ->
//    aborted=1, done=0, no further dp_start, irq=0.
//  4 NITER=0, START -> no dp_start, done=1 next cycle.
//    START+ABORT in one write -> nothing happens.
//  5 START while busy, and a NITER write while busy -> run count unchanged.
//    Stray dp_done in IDLE -> no state change.
//  6 IRQ: after completion, write IRQ_CLR -> irq=0 next cycle.
//    Assert reset during WAIT -> FSM IDLE, all outputs 0.

Source files
------------

// File: rtl/ransac_iter_sequencer.sv
// rtl/ransac_iter_sequencer.sv - Avalon-MM RANSAC iteration sequencer; optional completion irq via RANSAC_SEQ_IRQ_EN
module ransac_iter_sequencer #(
  parameter int ITER_W  = 16,
  parameter int SCORE_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         address,
  input  logic               write,
  input  logic [31:0]        writedata,
  input  logic               read,
  output logic [31:0]        readdata,
  output logic               dp_start,
  output logic [ITER_W-1:0]  dp_iter,
  input  logic               dp_done,
  input  logic [SCORE_W-1:0] dp_score,
  output logic               irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ITER_W-1:0]  niter;
  logic [ITER_W-1:0]  best_idx;
  logic [SCORE_W-1:0] best_score;
  logic [SCORE_W-1:0] score_q;
  logic               done;
  logic               aborted;
  logic               irq_pend;
  logic               busy;

  logic ctrl_wr, start_req, abort_req, irq_clr_req;
  logic start_run, start_empty, abort_run, last_iter, done_set;

  // ABORT in the same CTRL write masks START
  assign ctrl_wr     = write && (address == 2'd0);
  assign start_req   = ctrl_wr && writedata[0] && !writedata[1];
  assign abort_req   = ctrl_wr && writedata[1];
  assign irq_clr_req = ctrl_wr && writedata[2];

  assign start_run   = (state == S_IDLE) && start_req && (niter != '0);
  assign start_empty = (state == S_IDLE) && start_req && (niter == '0);
  assign abort_run   = busy && abort_req;
  assign last_iter   = (dp_iter == niter - ITER_W'(1));
  assign done_set    = start_empty || ((state == S_UPDATE) && !abort_req && last_iter);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort from any busy state returns straight to idle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_run) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = abort_req ? S_IDLE : S_WAIT;
      S_WAIT:   if (abort_req) state_nxt = S_IDLE;
                else if (dp_done) state_nxt = S_UPDATE;
      S_UPDATE: if (abort_req) state_nxt = S_IDLE;
                else state_nxt = last_iter ? S_DONE : S_ISSUE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    dp_start = (state == S_ISSUE);
    busy     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_UPDATE);
  end

  // Run bookkeeping: iteration count, index, best result and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      niter      <= '0;
      dp_iter    <= '0;
      best_score <= '0;
      best_idx   <= '0;
      score_q    <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      if (write && (address == 2'd1) && !busy)
        niter <= writedata[ITER_W-1:0];
      if ((state == S_WAIT) && dp_done)
        score_q <= dp_score;
      if (start_run) begin
        best_score <= '0;
        best_idx   <= '0;
        done       <= 1'b0;
        aborted    <= 1'b0;
        dp_iter    <= '0;
      end else if (start_empty) begin
        done    <= 1'b1;
        aborted <= 1'b0;
      end else if (abort_run) begin
        aborted <= 1'b1;
        done    <= 1'b0;
      end else if (state == S_UPDATE) begin
        if (score_q > best_score) begin
          best_score <= score_q;
          best_idx   <= dp_iter;
        end
        if (last_iter) done <= 1'b1;
        else           dp_iter <= dp_iter + ITER_W'(1);
      end
    end
  end

`ifdef RANSAC_SEQ_IRQ_EN
  // Pending interrupt: set on completion, cleared by IRQ_CLR or a new start; set wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      irq_pend <= 1'b0;
    else if (done_set)                              irq_pend <= 1'b1;
    else if (irq_clr_req || start_run || start_empty) irq_pend <= 1'b0;
  end
  assign irq = irq_pend;
`else
  assign irq_pend = 1'b0;
  assign irq      = 1'b0;
`endif

  logic [63:0] status_wide;
  logic [63:0] best_wide;

  // Status and best-result words before truncation to the 32-bit bus
  always_comb begin
    status_wide      = 64'(dp_iter) << 16;
    status_wide[3:0] = {irq_pend, aborted, done, busy};
    if (SCORE_W >= 32) best_wide = 64'(best_score);
    else               best_wide = (64'(best_idx) << SCORE_W) | 64'(best_score);
  end

  // Registered read mux, one-cycle latency, returned whether or not read is asserted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else begin
      case (address)
        2'd0:    readdata <= '0;
        2'd1:    readdata <= 32'(niter);
        2'd2:    readdata <= status_wide[31:0];
        default: readdata <= best_wide[31:0];
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, read, writedata, irq_clr_req, done_set,
                         status_wide[63:32], best_wide[63:32]};

endmodule
